pea_token_fifo: RTL and testbench

Single-clock token FIFO that buffers the PEA input and output streams: the Command Input FIFO, Data Input FIFO, Result Output FIFO and Status Output FIFO. Writer-side signals are wr_en and din; the block reports free_space. Reader-side signals are rd_en and dout; the block reports pop. Its pop and free_space ports connect directly to the PEA top module's command_pop, data_pop, result_free_space and status_free_space inputs. It is instantiated twice at word_size and twice at 2*word_size.

---
 rtl/pea_pkg.sv | 26 ++
 rtl/pea_fifo_ram.sv | 38 +++
 rtl/pea_token_fifo.sv | 123 ++++++++++++
 tb/tb_pea_token_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pea_pkg.sv
// Shared definitions for the PEA token FIFOs and command decoding.
package pea_pkg;

    // Default token width and RAM depth of a token FIFO.
    localparam int WORD_SIZE   = 16;
    localparam int BUFFER_SIZE = 1024;

    // Command token fields.
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 8;
    localparam int ARG1_MSB   = 7;
    localparam int ARG1_LSB   = 5;
    localparam int ARG2_MSB   = 4;
    localparam int ARG2_LSB   = 0;

    // Ceiling log2, usable in parameter expressions.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pea_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with
// read enable, so the read register holds its value between reads.
module pea_fifo_ram
    import pea_pkg::*;
#(
    parameter int word_size   = WORD_SIZE,
    parameter int buffer_size = BUFFER_SIZE,
    parameter int AW          = log2(buffer_size)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [word_size-1:0] i_wdata,
    input  logic                 i_re,
    input  logic [AW-1:0]        i_raddr,
    output logic [word_size-1:0] o_rdata
);

    logic [word_size-1:0] r_mem [buffer_size];
    logic [word_size-1:0] r_rdata;

    // Write port: store the token at the write address.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: capture the addressed word only when a read is accepted.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pea_token_fifo.sv
// Single-clock token FIFO with registered occupancy/free-space reporting
// and sticky overflow/underflow flags. Usable capacity is buffer_size-1.
module pea_token_fifo
    import pea_pkg::*;
#(
    parameter int word_size   = WORD_SIZE,
    parameter int buffer_size = BUFFER_SIZE,
    parameter int AW          = log2(buffer_size)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [word_size-1:0] din,
    input  logic                 rd_en,
    output logic [word_size-1:0] dout,
    output logic [AW-1:0]        pop,
    output logic [AW-1:0]        free_space,
    output logic                 empty,
    output logic                 full,
    input  logic                 clr_err,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [AW-1:0] MAX_POP = AW'(buffer_size - 1);

    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW-1:0]        r_pop;
    logic [AW-1:0]        r_free;
    logic                 r_empty;
    logic                 r_full;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 r_rd_seen;
    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic [AW-1:0]        w_pop_nxt;
    logic [word_size-1:0] w_ram_q;

    // Accept decisions use the registered (pre-edge) flags only.
    assign w_wr_ok = wr_en && !r_full;
    assign w_rd_ok = rd_en && !r_empty;

    pea_fifo_ram #(
        .word_size   (word_size),
        .buffer_size (buffer_size),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_re    (w_rd_ok),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    // Next population: simultaneous accepted read and write cancel out.
    always_comb begin
        w_pop_nxt = r_pop;
        if (w_wr_ok && !w_rd_ok) begin
            w_pop_nxt = r_pop + AW'(1);
        end else if (w_rd_ok && !w_wr_ok) begin
            w_pop_nxt = r_pop - AW'(1);
        end
    end

    // Pointers, occupancy and derived status, all registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pop     <= '0;
            r_free    <= MAX_POP;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_rd_seen <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_seen <= 1'b1;
            end
            r_pop   <= w_pop_nxt;
            r_free  <= MAX_POP - w_pop_nxt;
            r_empty <= (w_pop_nxt == '0);
            r_full  <= (w_pop_nxt == MAX_POP);
        end
    end

    // Sticky error flags; a new error at the same edge beats clr_err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (wr_en && r_full) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
            if (rd_en && r_empty) begin
                r_unf <= 1'b1;
            end else if (clr_err) begin
                r_unf <= 1'b0;
            end
        end
    end

    // The RAM read register is not reset, so dout reads zero until the
    // first accepted read after reset.
    assign dout       = r_rd_seen ? w_ram_q : '0;
    assign pop        = r_pop;
    assign free_space = r_free;
    assign empty      = r_empty;
    assign full       = r_full;
    assign overflow   = r_ovf;
    assign underflow  = r_unf;

endmodule

// File: tb/tb_pea_token_fifo.sv
// Directed bench for pea_token_fifo (word_size 16, buffer_size 1024).
module tb_pea_token_fifo;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [15:0] din;
    logic        rd_en;
    logic [15:0] dout;
    logic [9:0]  pop;
    logic [9:0]  free_space;
    logic        empty;
    logic        full;
    logic        clr_err;
    logic        overflow;
    logic        underflow;

    int n_checks;
    int n_errors;

    pea_token_fifo #(
        .word_size   (16),
        .buffer_size (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .din        (din),
        .rd_en      (rd_en),
        .dout       (dout),
        .pop        (pop),
        .free_space (free_space),
        .empty      (empty),
        .full       (full),
        .clr_err    (clr_err),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [15:0] exp_dout);
        check({tag, "_pop"},   32'(pop), 32'd0);
        check({tag, "_free"},  32'(free_space), 32'd1023);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"},  32'(full), 32'd0);
        check({tag, "_dout"},  32'(dout), 32'(exp_dout));
        check({tag, "_ovf"},   32'(overflow), 32'd0);
        check({tag, "_unf"},   32'(underflow), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        wr_en    = 1'b0;
        din      = '0;
        rd_en    = 1'b0;
        clr_err  = 1'b0;

        // Reset then idle.
        tick; tick;
        check_idle("in_reset", 16'h0000);
        rst = 1'b1;
        tick; tick;
        check_idle("after_reset", 16'h0000);

        // Five writes then five reads, data in order.
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1;
            din   = 16'(i);
            tick;
        end
        wr_en = 1'b0;
        check("five_pop", 32'(pop), 32'd5);
        check("five_free", 32'(free_space), 32'd1018);
        check("five_empty", 32'(empty), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            rd_en = 1'b1;
            tick;
            check("five_dout", 32'(dout), 32'(i));
        end
        rd_en = 1'b0;
        tick;
        check("five_hold", 32'(dout), 32'd5);
        check("five_end_pop", 32'(pop), 32'd0);
        check("five_end_empty", 32'(empty), 32'd1);

        // Fill to capacity, then one extra write that must be dropped.
        for (int i = 0; i < 1023; i++) begin
            wr_en = 1'b1;
            din   = 16'(i);
            tick;
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_pop", 32'(pop), 32'd1023);
        check("fill_free", 32'(free_space), 32'd0);
        check("fill_ovf_before", 32'(overflow), 32'd0);
        din = 16'hBEEF;
        tick;
        wr_en = 1'b0;
        check("extra_ovf", 32'(overflow), 32'd1);
        check("extra_pop", 32'(pop), 32'd1023);
        check("extra_full", 32'(full), 32'd1);

        // Write while full with an accepted read at the same edge: write dropped.
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 16'hBEEF;
        tick;
        wr_en = 1'b0;
        check("full_rw_dout", 32'(dout), 32'd0);
        check("full_rw_pop", 32'(pop), 32'd1022);
        // Drain the rest; never 0xBEEF.
        for (int i = 1; i < 1023; i++) begin
            rd_en = 1'b1;
            tick;
            check("drain_dout", 32'(dout), 32'(i));
        end
        rd_en = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_pop", 32'(pop), 32'd0);
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);

        // Read on empty with a simultaneous write.
        rd_en = 1'b1;
        wr_en = 1'b1;
        din   = 16'h1234;
        tick;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("emp_unf", 32'(underflow), 32'd1);
        check("emp_pop", 32'(pop), 32'd1);
        check("emp_dout_hold", 32'(dout), 32'd1022);
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check("emp_next_dout", 32'(dout), 32'h1234);
        check("emp_next_pop", 32'(pop), 32'd0);

        // clr_err together with a new underflow: the flag stays set.
        clr_err = 1'b1;
        rd_en   = 1'b1;
        tick;
        rd_en = 1'b0;
        check("clr_vs_new_unf", 32'(underflow), 32'd1);
        check("clr_vs_new_dout", 32'(dout), 32'h1234);
        tick;
        clr_err = 1'b0;
        check("clr_unf", 32'(underflow), 32'd0);

        // Wrap-around: steady pop of 1 with continuous read+write.
        wr_en = 1'b1;
        din   = 16'h0000;
        tick;
        for (int k = 0; k < 3000; k++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            din   = 16'(k + 1);
            tick;
            check("wrap_dout", 32'(dout), 32'(k));
            check("wrap_pop", 32'(pop), 32'd1);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("wrap_ovf", 32'(overflow), 32'd0);
        check("wrap_unf", 32'(underflow), 32'd0);
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check("wrap_last", 32'(dout), 32'd3000);
        check("wrap_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-stream at pop=700.
        for (int i = 0; i < 700; i++) begin
            wr_en = 1'b1;
            din   = 16'(16'h5000 + i);
            tick;
        end
        wr_en = 1'b0;
        check("pre_rst_pop", 32'(pop), 32'd700);
        #2;
        rst = 1'b0;
        #1;
        check_idle("mid_rst", 16'h0000);
        tick;
        rst = 1'b1;
        tick;
        wr_en = 1'b1;
        din   = 16'hCAFE;
        tick;
        wr_en = 1'b0;
        check("post_rst_pop", 32'(pop), 32'd1);
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check("post_rst_dout", 32'(dout), 32'hCAFE);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
